// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline constants for the five-stage core
//
// Purpose: control-word bit positions, forwarding-select encodings and the
// default control/register-index widths used by the ID/EX stage.
// Ports: none (package).

package pipe_pkg;

  localparam int CTRL_W = 9;
  localparam int REG_W  = 5;

  // Control word bit map, MSB to LSB.
  localparam int CTRL_REGDST   = 8;
  localparam int CTRL_ALUOP_HI = 7;
  localparam int CTRL_ALUOP_LO = 6;
  localparam int CTRL_ALUSRC   = 5;
  localparam int CTRL_BRANCH   = 4;
  localparam int CTRL_MEMREAD  = 3;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_REGWRITE = 1;
  localparam int CTRL_MEMTOREG = 0;

  // Forwarding mux select encodings.
  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_MEMWB = 2'd1;
  localparam logic [1:0] FWD_EXMEM = 2'd2;

endpackage

// File: rtl/forward_unit.sv
// rtl/forward_unit.sv - EX-stage forwarding select generation
//
// Purpose: purely combinational; picks the source of each ALU operand.
// Ports:
//   ex_rs, ex_rt          in  IDX_W : source registers of the EX instruction
//   exmem_regwrite/rd     in  1/IDX_W : writer in EX/MEM
//   memwb_regwrite/rd     in  1/IDX_W : writer in MEM/WB
//   forward_a, forward_b  out 2 : mux selects (FWD_RF / FWD_MEMWB / FWD_EXMEM)

module forward_unit
  import pipe_pkg::*;
#(
  parameter int IDX_W = 5
) (
  input  logic [IDX_W-1:0] ex_rs,
  input  logic [IDX_W-1:0] ex_rt,
  input  logic             exmem_regwrite,
  input  logic [IDX_W-1:0] exmem_rd,
  input  logic             memwb_regwrite,
  input  logic [IDX_W-1:0] memwb_rd,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b
);

  logic exmem_live;
  logic memwb_live;

  // A writer to register 0 never produces a forwardable value.
  assign exmem_live = exmem_regwrite && (exmem_rd != '0);
  assign memwb_live = memwb_regwrite && (memwb_rd != '0);

  // EX/MEM is checked first: it holds the younger result.
  always_comb begin
    forward_a = FWD_RF;
    if (exmem_live && (exmem_rd == ex_rs)) begin
      forward_a = FWD_EXMEM;
    end else if (memwb_live && (memwb_rd == ex_rs)) begin
      forward_a = FWD_MEMWB;
    end
  end

  always_comb begin
    forward_b = FWD_RF;
    if (exmem_live && (exmem_rd == ex_rt)) begin
      forward_b = FWD_EXMEM;
    end else if (memwb_live && (memwb_rd == ex_rt)) begin
      forward_b = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use and forwarding
//
// Purpose: captures decoded control, operands, immediate and PC+4 from ID,
// detects load-use hazards, drives the ID bubble-mux select and the EX
// forwarding selects, and counts inserted bubbles (saturating).
// Ports:
//   clk, rst_n                   : clock, async active-low reset
//   hold                         : freeze all ID/EX state
//   flush                        : load a bubble on the next capture
//   id_ctrl/rs/rt/rd/rdata_a/b/imm/pc4 : ID-stage inputs
//   exmem_regwrite/rd, memwb_regwrite/rd : downstream writers
//   ex_ctrl/rs/rt/rd/rdata_a/b/imm/pc4  : registered EX-stage outputs
//   pc_write, ifid_write, ctrl_sel      : load-use stall controls
//   forward_a, forward_b                : forwarding mux selects
//   bubble_cnt                          : saturating bubble count

module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CTRL_W = 9,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              flush,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [DATA_W-1:0] id_rdata_a,
  input  logic [DATA_W-1:0] id_rdata_b,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic              exmem_regwrite,
  input  logic [REG_W-1:0]  exmem_rd,
  input  logic              memwb_regwrite,
  input  logic [REG_W-1:0]  memwb_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_rd,
  output logic [DATA_W-1:0] ex_rdata_a,
  output logic [DATA_W-1:0] ex_rdata_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc4,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ctrl_sel,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic stall;
  logic load_bubble;

  // A load in EX whose destination is read by the instruction in ID.
  assign stall = ex_ctrl[pipe_pkg::CTRL_MEMREAD] && (ex_rt != '0) &&
                 ((ex_rt == id_rs) || (ex_rt == id_rt));

  assign pc_write   = !stall;
  assign ifid_write = !stall;
  assign ctrl_sel   = stall;

  // hold wins over both flush and stall, so a held stall inserts nothing.
  assign load_bubble = !hold && (flush || stall);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ctrl    <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      ex_rdata_a <= '0;
      ex_rdata_b <= '0;
      ex_imm     <= '0;
      ex_pc4     <= '0;
      bubble_cnt <= '0;
    end else if (!hold) begin
      ex_ctrl    <= (flush || stall) ? '0 : id_ctrl;
      ex_rs      <= id_rs;
      ex_rt      <= id_rt;
      ex_rd      <= id_rd;
      ex_rdata_a <= id_rdata_a;
      ex_rdata_b <= id_rdata_b;
      ex_imm     <= id_imm;
      ex_pc4     <= id_pc4;
      if (load_bubble && (bubble_cnt != '1)) begin
        bubble_cnt <= bubble_cnt + 1'b1;
      end
    end
  end

  forward_unit #(
    .IDX_W (REG_W)
  ) u_forward_unit (
    .ex_rs          (ex_rs),
    .ex_rt          (ex_rt),
    .exmem_regwrite (exmem_regwrite),
    .exmem_rd       (exmem_rd),
    .memwb_regwrite (memwb_regwrite),
    .memwb_rd       (memwb_rd),
    .forward_a      (forward_a),
    .forward_b      (forward_b)
  );

endmodule
